// File: rtl/aes_sub_bytes_seq.sv
// aes_sub_bytes_seq: sequential AES SubBytes, streams 16 state bytes through N_SBOX external S-box lanes
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake; in_data is the 128-bit state (byte 0 in bits [127:120])
//   sbox_a/sbox_b        lane j drives/returns bits [8j+7:8j] of the external combinational S-boxes
//   out_valid/out_ready  output handshake; out_data is the substituted state, same byte order
//   busy                 high while bytes are being substituted
module aes_sub_bytes_seq #(
  parameter int N_SBOX = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  output logic [8*N_SBOX-1:0] sbox_a,
  input  logic [8*N_SBOX-1:0] sbox_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data,
  output logic                busy
);
  localparam int S = 16 / N_SBOX;
  localparam int CW = S > 1 ? $clog2(S) : 1;
  // top N_SBOX bytes set; shifted down to select the bytes written in the current step
  localparam logic [127:0] TOP = ~({128{1'b1}} >> (8 * N_SBOX));
  if (N_SBOX != 1 && N_SBOX != 2 && N_SBOX != 4 && N_SBOX != 8 && N_SBOX != 16) begin : g_bad
    $error("aes_sub_bytes_seq: N_SBOX must be 1, 2, 4, 8 or 16");
  end
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [127:0] r_in, r_out, w_win, w_lanes;
  logic [7:0] w_sh;
  logic w_last;
  // bit offset of the first byte handled in this step; the current window sits at the top of w_win
  assign w_sh = 8'(r_cnt) * 8'(8 * N_SBOX);
  assign w_win = r_in << w_sh;
  assign w_last = r_cnt == CW'(S - 1);
  assign out_data = r_out;
  always_comb begin
    w_next = (r_state == IDLE && in_valid) ? BUSY :
             (r_state == BUSY && w_last)   ? DONE :
             (r_state == DONE && out_ready) ? IDLE : r_state;
    in_ready = r_state == IDLE;
    out_valid = r_state == DONE;
    busy = r_state == BUSY;
    sbox_a = '0;
    w_lanes = '0;
    for (int j = 0; j < N_SBOX; j++) begin
      sbox_a[8*j +: 8] = (r_state == BUSY) ? w_win[127-8*j -: 8] : 8'h00;
      w_lanes[127-8*j -: 8] = sbox_b[8*j +: 8];
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt <= '0;
      r_in <= '0;
      r_out <= '0;
    end else begin
      if (r_state == IDLE && in_valid) begin
        r_in <= in_data;
        r_cnt <= '0;
      end
      if (r_state == BUSY) begin
        r_cnt <= w_last ? '0 : r_cnt + CW'(1);
        r_out <= (r_out & ~(TOP >> w_sh)) | (w_lanes >> w_sh);
      end
    end
endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// tb_aes_sub_bytes_seq: directed scoreboard bench for aes_sub_bytes_seq with 1, 4 and 16 S-box lanes
module tb_aes_sub_bytes_seq;
  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};
  localparam logic [127:0] VEC = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] VEC_SUB = 128'h638293c31bfc33f5c4eeacea4bc12816;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, in_valid, out_ready, iv_w, or_w;
  logic [127:0] in_data;
  logic in_ready, out_valid, busy;
  logic [127:0] out_data;
  logic [7:0] sa1, sb1;
  logic ir4, ov4, bz4;
  logic [127:0] od4;
  logic [31:0] sa4, sb4;
  logic ir16, ov16, bz16;
  logic [127:0] od16, sa16, sb16;
  assign sb1 = SBOX[sa1];
  for (genvar j = 0; j < 4; j++) begin : g_l4
    assign sb4[8*j +: 8] = SBOX[sa4[8*j +: 8]];
  end
  for (genvar j = 0; j < 16; j++) begin : g_l16
    assign sb16[8*j +: 8] = SBOX[sa16[8*j +: 8]];
  end
  aes_sub_bytes_seq #(.N_SBOX(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sbox_a(sa1), .sbox_b(sb1), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy));
  aes_sub_bytes_seq #(.N_SBOX(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_w), .in_ready(ir4), .in_data(in_data),
    .sbox_a(sa4), .sbox_b(sb4), .out_valid(ov4), .out_ready(or_w),
    .out_data(od4), .busy(bz4));
  aes_sub_bytes_seq #(.N_SBOX(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_w), .in_ready(ir16), .in_data(in_data),
    .sbox_a(sa16), .sbox_b(sb16), .out_valid(ov16), .out_ready(or_w),
    .out_data(od16), .busy(bz16));
  int checks = 0, errors = 0, cyc = 0;
  logic acc;
  logic [127:0] q[$];
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, 128'(obs), 128'(exp));
  endtask
  // one clock: sample at negedge (scoreboard pop on handshake), then return 1ns after posedge
  task automatic step();
    @(negedge clk);
    acc = in_valid && in_ready;
    chk1("excl", out_valid && in_ready, 1'b0);
    if (out_valid && out_ready) begin
      chk1("sb_nonempty", q.size() != 0, 1'b1);
      if (q.size() != 0) chk("out", out_data, q.pop_front());
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask
  // leaves in_valid high; caller drops it
  task automatic send(input logic [127:0] d, input logic [127:0] e, output int t);
    in_data = d;
    in_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) step();
    chk1("accept", acc, 1'b1);
    if (acc) q.push_back(e);
    t = cyc;
  endtask
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
    chk1("ov_timeout", out_valid, 1'b1);
  endtask
  task automatic wait_empty();
    for (int i = 0; i < 100 && q.size() != 0; i++) step();
    chk("sb_drain", 128'(q.size()), 128'd0);
  endtask
  initial begin
    int n, t, t1, t2, l4, l16;
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    iv_w = 1'b0;
    or_w = 1'b0;
    in_data = '0;
    #1 rst_n = 1'b0;
    #2;
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_sbox_a", 128'(sa1), 128'd0);
    chk("rst16_out_data", od16, 128'd0);
    chk("rst16_sbox_a", sa16, 128'd0);
    chk1("rst4_in_ready", ir4, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    // zero state, latency, then backpressure
    send('0, {16{8'h63}}, t);
    in_valid = 1'b0;
    chk1("busy_hi", busy, 1'b1);
    chk1("busy_in_ready", in_ready, 1'b0);
    wait_out(n);
    chk("lat1", 128'(n), 128'd16);
    for (int i = 0; i < 20; i++) begin
      step();
      chk1("bp_out_valid", out_valid, 1'b1);
      chk1("bp_in_ready", in_ready, 1'b0);
      chk("bp_out_data", out_data, {16{8'h63}});
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk1("hs_in_ready", in_ready, 1'b1);
    chk1("hs_out_valid", out_valid, 1'b0);
    chk("idle_retain", out_data, {16{8'h63}});
    // known vector, with in_data changed while busy
    send(VEC, VEC_SUB, t);
    in_valid = 1'b0;
    chk("lane_b0", 128'(sa1), 128'h00);
    in_data = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    step();
    chk("lane_b1", 128'(sa1), 128'h11);
    wait_out(n);
    chk("lat2", 128'(n + 1), 128'd16);
    out_ready = 1'b1;
    wait_empty();
    // back-to-back with in_valid held high
    send('0, {16{8'h63}}, t1);
    in_data = '1;
    send('1, {16{8'h16}}, t2);
    in_valid = 1'b0;
    chk("spacing", 128'(t2 - t1), 128'd18);
    wait_empty();
    // reset abort mid-busy
    send(VEC, VEC_SUB, t);
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) step();
    rst_n = 1'b0;
    #2;
    chk1("abort_out_valid", out_valid, 1'b0);
    chk1("abort_in_ready", in_ready, 1'b1);
    chk1("abort_busy", busy, 1'b0);
    chk("abort_out_data", out_data, 128'd0);
    chk("abort_sbox_a", 128'(sa1), 128'd0);
    q.delete();
    step();
    rst_n = 1'b1;
    send({16{8'h53}}, {16{8'hed}}, t);
    in_valid = 1'b0;
    wait_empty();
    // single non-zero byte at byte 0
    send({8'h01, 120'd0}, 128'h7c636363636363636363636363636363, t);
    in_valid = 1'b0;
    wait_empty();
    out_ready = 1'b0;
    // 4 and 16 lanes
    in_data = VEC;
    iv_w = 1'b1;
    step();
    iv_w = 1'b0;
    l4 = -1;
    l16 = -1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (ov4 && l4 < 0) l4 = k;
      if (ov16 && l16 < 0) l16 = k;
    end
    chk("lat4", 128'(l4), 128'd4);
    chk("lat16", 128'(l16), 128'd1);
    chk("out4", od4, VEC_SUB);
    chk("out16", od16, VEC_SUB);
    chk1("done4_in_ready", ir4, 1'b0);
    chk1("done16_busy", bz16, 1'b0);
    or_w = 1'b1;
    step();
    or_w = 1'b0;
    chk1("hs4_in_ready", ir4, 1'b1);
    chk1("hs16_in_ready", ir16, 1'b1);
    chk1("hs4_out_valid", ov4, 1'b0);
    chk("sb_empty", 128'(q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
